// File: rtl/fifo_rr_read_scheduler.sv
// fifo_rr_read_scheduler: round-robin burst reader merging N_SRC show-ahead-off FIFOs into one tagged valid/ready stream
module fifo_rr_read_scheduler #(
    parameter int N_SRC = 4,
    parameter int DW    = 32,
    parameter int BURST = 4,
    localparam int SW   = $clog2(N_SRC)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [N_SRC-1:0]  fifo_empty_i,
    output logic [N_SRC-1:0]  fifo_req_o,
    input  logic [N_SRC-1:0]  fifo_valid_i,
    input  logic [N_SRC*DW-1:0] fifo_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DW-1:0]     m_data_o,
    output logic [SW-1:0]     m_src_o,
    output logic [N_SRC-1:0]  grant_o,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [SW-1:0] g_q, g_d, ptr_q, ptr_d, src_q, pick, cand;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] occ_q, occ_d;
    logic inflight_q, err_q, found, req, pop, wr, wi;
    logic [DW-1:0] data_q [2], data_d [2];
    logic [SW-1:0] tag_q [2], tag_d [2];

    always_comb begin
        pick = '0;
        cand = '0;
        found = 1'b0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = SW'((int'(ptr_q) + i) % N_SRC);
            if (!found && !fifo_empty_i[cand]) begin
                pick = cand;
                found = 1'b1;
            end
        end
    end

    // Credit counts the slot freed by this cycle's transfer, allowing 1 word/clk.
    assign pop = (occ_q != 2'd0) && m_ready_i;
    assign req = (state_q == GRANT) && !fifo_empty_i[g_q]
               && (({1'b0, occ_q} - {2'b0, pop} + {2'b0, inflight_q}) < 3'd2);
    assign wr  = inflight_q && fifo_valid_i[src_q];
    assign wi  = (occ_q - {1'b0, pop}) != 2'd0;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = req ? cnt_q + 8'd1 : cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                g_d     = pick;
                ptr_d   = pick;
                cnt_d   = '0;
            end
        end else if (fifo_empty_i[g_q] || (req && cnt_q == 8'(BURST - 1))) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        occ_d  = occ_q - {1'b0, pop} + {1'b0, wr};
        if (pop) begin
            data_d[0] = data_q[1];
            tag_d[0]  = tag_q[1];
        end
        if (wr) begin
            data_d[wi] = fifo_data_i[int'(src_q)*DW +: DW];
            tag_d[wi]  = src_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= IDLE;
            g_q        <= '0;
            ptr_q      <= SW'(N_SRC - 1);
            cnt_q      <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            src_q      <= '0;
            err_q      <= 1'b0;
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            inflight_q <= req;
            src_q      <= req ? g_q : src_q;
            err_q      <= err_q | (inflight_q & ~fifo_valid_i[src_q]);
            data_q     <= data_d;
            tag_q      <= tag_d;
        end
    end

    assign grant_o    = (state_q == GRANT) ? N_SRC'(1) << g_q : '0;
    assign fifo_req_o = req ? grant_o : '0;
    assign m_valid_o  = occ_q != 2'd0;
    assign m_data_o   = data_q[0];
    assign m_src_o    = tag_q[0];
    assign busy_o     = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);
    assign err_o      = err_q;
endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// tb_fifo_rr_read_scheduler: queue-based source FIFOs plus a transaction-level scheduler model checked every cycle,
// with literal expectations on grant order, burst lengths and word order per directed scenario.
module tb_fifo_rr_read_scheduler;
    localparam int N = 4, DW = 32, B = 4, SW = 2;
    typedef struct packed { logic [SW-1:0] s; logic [DW-1:0] d; } ent_t;
    typedef logic [DW-1:0] wq_t [$];

    logic clk = 1'b0, srst_i = 1'b1, m_ready_i = 1'b1;
    logic m_valid_o, busy_o, err_o;
    logic [N-1:0] fifo_empty_i = '1, fifo_valid_i = '0, fifo_req_o, grant_o;
    logic [N*DW-1:0] fifo_data_i = '0;
    logic [DW-1:0] m_data_o;
    logic [SW-1:0] m_src_o;

    wq_t srcq [N];
    int wcnt [N], nreq [N];
    ent_t bufq [$], pendq [$], outlog [$];
    int glog [$], blog [$];
    int checks = 0, errors = 0, cnt_m = 0, ptr_m = N - 1;
    bit rst_k = 1, rdy_k = 1, sup_k = 0, sup_prev = 0, have_rst = 0, err_m = 0, inflight_m = 0;
    logic [N-1:0] grant_m = '0, req_m_prev = '0, empty_prev = '1, dut_req_prev = '0;

    fifo_rr_read_scheduler #(.N_SRC(N), .DW(DW), .BURST(B)) dut (
        .clk_i(clk), .srst_i(srst_i), .fifo_empty_i(fifo_empty_i), .fifo_req_o(fifo_req_o),
        .fifo_valid_i(fifo_valid_i), .fifo_data_i(fifo_data_i), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_src_o(m_src_o), .grant_o(grant_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: update sources and model, then compare all outputs against the model.
    task automatic step();
        bit rst_prev, pop;
        logic [N-1:0] g_exp, req_m;
        int c;
        @(negedge clk);
        rst_prev = srst_i;
        srst_i = rst_k;
        m_ready_i = rdy_k;
        have_rst |= rst_prev;
        inflight_m = (req_m_prev != 0) && !rst_prev;
        err_m = !rst_prev && (err_m || sup_prev);
        sup_prev = 0;
        if (rst_prev) bufq.delete();
        else foreach (pendq[i]) bufq.push_back(pendq[i]);
        pendq.delete();
        fifo_valid_i = '0;
        for (int k = 0; k < N; k++)
            if (dut_req_prev[k] === 1'b1 && srcq[k].size() != 0) begin
                ent_t e;
                e.s = SW'(k);
                e.d = srcq[k].pop_front();
                fifo_data_i[k*DW +: DW] = e.d;
                if (sup_k && !rst_prev) begin
                    sup_k = 0;
                    sup_prev = 1;
                end else begin
                    fifo_valid_i[k] = 1'b1;
                    if (!rst_prev) pendq.push_back(e);
                end
            end
        for (int k = 0; k < N; k++) fifo_empty_i[k] = srcq[k].size() == 0;
        g_exp = '0;
        if (rst_prev) begin
            ptr_m = N - 1;
            cnt_m = 0;
        end else if (grant_m == 0) begin
            for (int i = 1; i <= N; i++) begin
                c = (ptr_m + i) % N;
                if (g_exp == 0 && !empty_prev[c]) begin
                    g_exp[c] = 1'b1;
                    ptr_m = c;
                    cnt_m = 0;
                    glog.push_back(c);
                end
            end
        end else if (cnt_m != B && (grant_m & empty_prev) == 0) g_exp = grant_m;
        if (grant_m != 0 && g_exp == 0 && !rst_prev) blog.push_back(cnt_m);
        grant_m = g_exp;
        #1;
        pop = bufq.size() != 0 && m_ready_i;
        req_m = (grant_m != 0 && (grant_m & fifo_empty_i) == 0
                 && bufq.size() - int'(pop) + int'(inflight_m) < 2) ? grant_m : '0;
        if (have_rst) begin
            chk("grant_o", grant_o, grant_m);
            chk("fifo_req_o", fifo_req_o, req_m);
            chk("m_valid_o", m_valid_o, bufq.size() != 0);
            if (bufq.size() != 0) chk("m_word", {m_src_o, m_data_o}, bufq[0]);
            chk("busy_o", busy_o, grant_m != 0 || inflight_m || bufq.size() != 0);
            chk("err_o", err_o, err_m);
        end
        if (pop) outlog.push_back(bufq.pop_front());
        if (req_m != 0) cnt_m++;
        for (int k = 0; k < N; k++) nreq[k] += int'(fifo_req_o[k] === 1'b1);
        dut_req_prev = fifo_req_o;
        req_m_prev = req_m;
        empty_prev = fifo_empty_i;
    endtask

    task automatic push(int k, int n);
        for (int i = 0; i < n; i++) begin
            srcq[k].push_back(DW'(((k + 1) << 8) + wcnt[k]));
            wcnt[k]++;
        end
    endtask

    task automatic clear_logs();
        glog.delete();
        blog.delete();
        outlog.delete();
        for (int k = 0; k < N; k++) nreq[k] = 0;
    endtask

    task automatic reset_dut();
        for (int k = 0; k < N; k++) begin
            srcq[k].delete();
            wcnt[k] = 0;
        end
        sup_k = 0;
        rdy_k = 1;
        rst_k = 1;
        step();
        step();
        rst_k = 0;
        clear_logs();
    endtask

    task automatic run_until(int n, int budget, string name);
        int i = 0;
        while (outlog.size() < n && i < budget) begin
            step();
            i++;
        end
        chk(name, outlog.size(), n);
        repeat (4) step();
    endtask

    initial begin
        ent_t e;
        reset_dut();
        step();
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", m_valid_o, 0);

        // 1: single source, fewer words than a burst
        reset_dut();
        push(0, 3);
        run_until(3, 30, "t1_words");
        chk("t1_reqs", nreq[0], 3);
        chk("t1_grants", glog.size(), 1);
        chk("t1_burst", blog.size() == 1 ? blog[0] : -1, 3);
        for (int i = 0; i < 3; i++) chk("t1_order", outlog[i], {2'd0, 32'h100 + 32'(i)});

        // 2: all sources busy, full bursts in round-robin order
        reset_dut();
        for (int k = 0; k < N; k++) push(k, 8);
        run_until(32, 200, "t2_words");
        chk("t2_ngrants", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) chk("t2_gorder", glog[i], i % 4);
        for (int i = 0; i < 8 && i < blog.size(); i++) chk("t2_burst", blog[i], 4);
        for (int i = 0; i < 32; i++) begin
            e.s = SW'((i / 4) % 4);
            e.d = DW'((((i / 4) % 4 + 1) << 8) + (i / 16) * 4 + i % 4);
            chk("t2_order", outlog[i], e);
        end

        // 3: backpressure holds the grant after two reqs
        reset_dut();
        rdy_k = 0;
        push(1, 6);
        repeat (10) step();
        chk("t3_stall_reqs", nreq[1], 2);
        chk("t3_stall_valid", m_valid_o, 1);
        chk("t3_stall_word", {m_src_o, m_data_o}, {2'd1, 32'h200});
        rdy_k = 1;
        run_until(6, 60, "t3_words");
        for (int i = 0; i < 6; i++) chk("t3_order", outlog[i], {2'd1, 32'h200 + 32'(i)});

        // 4: src0 arrives mid-burst of src2 and is served next
        reset_dut();
        push(2, 4);
        repeat (3) step();
        push(0, 2);
        run_until(6, 60, "t4_words");
        chk("t4_ngrants", glog.size(), 2);
        chk("t4_first", glog[0], 2);
        chk("t4_second", glog.size() > 1 ? glog[1] : -1, 0);

        // 5: reset while a req is outstanding and a word is buffered
        reset_dut();
        push(1, 8);
        repeat (3) step();
        rst_k = 1;
        push(0, 2);
        push(2, 2);
        step();
        rst_k = 0;
        clear_logs();
        step();
        chk("t5_out", {grant_o, fifo_req_o, m_valid_o, m_data_o, m_src_o, busy_o, err_o}, 0);
        run_until(9, 80, "t5_words");
        chk("t5_ngrants", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t5_gorder", glog[i], (i == 0) ? 0 : (i == 2) ? 2 : 1);
        chk("t5_first_word", outlog[0], {2'd0, 32'h100});
        chk("t5_resume_src1", outlog.size() > 2 ? outlog[2] : '0, {2'd1, 32'h203});

        // 6: a missing valid sets the sticky error; remaining words still flow
        reset_dut();
        push(2, 4);
        sup_k = 1;
        run_until(3, 40, "t6_words");
        chk("t6_err", err_o, 1);
        chk("t6_first", outlog[0], {2'd2, 32'h301});
        chk("t6_reqs", nreq[2], 4);
        repeat (5) step();
        chk("t6_err_sticky", err_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
